// File: rtl/dvi_timing_gen.sv
// 640x480@60 raster timing generator for the DVI output path. Paces read strobes to the frame
// buffer's read FIFO, unpacks 32-bit words to RGB888 and reports frame boundaries/underflow.
module dvi_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned RD_LATENCY  = 2,  // must be at least 1
  parameter int unsigned PRIME_LEVEL = 256
) (
  input  logic        dvi_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] iData,
  input  logic [8:0]  rd_usedw,
  input  logic        rd_empty,
  output logic        rd_req,
  output logic        read_init,
  output logic        rd_new_frame,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic        oUnderflow,
  output logic [7:0]  oFrameCnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CntMax  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int unsigned CntW    = $clog2(CntMax);
  localparam int unsigned PipeLen = RD_LATENCY + 1;
  localparam int unsigned GateIdx = RD_LATENCY - 1;

  localparam logic [CntW-1:0] HLast   = CntW'(H_TOTAL - 1);
  localparam logic [CntW-1:0] VLast   = CntW'(V_TOTAL - 1);
  localparam logic [CntW-1:0] HAct    = CntW'(H_ACTIVE);
  localparam logic [CntW-1:0] VAct    = CntW'(V_ACTIVE);
  localparam logic [CntW-1:0] HSyncS  = CntW'(H_ACTIVE + H_FP);
  localparam logic [CntW-1:0] HSyncE  = CntW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CntW-1:0] VSyncS  = CntW'(V_ACTIVE + V_FP);
  localparam logic [CntW-1:0] VSyncE  = CntW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [8:0]      PrimeLv = 9'(PRIME_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] h_cnt_q, h_cnt_d;
  logic [CntW-1:0] v_cnt_q, v_cnt_d;
  logic [PipeLen-1:0] de_pipe_q, de_pipe_d;
  logic [PipeLen-1:0] hs_pipe_q, hs_pipe_d;
  logic [PipeLen-1:0] vs_pipe_q, vs_pipe_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic            uf_q, uf_d;
  logic [7:0]      fc_q, fc_d;

  logic run, h_last, v_last, raw_de, raw_hs, raw_vs, new_frame;
  logic unused_hi;

  assign unused_hi = ^iData[31:24];

  always_comb begin
    run       = (state_q == StRun);
    h_last    = (h_cnt_q == HLast);
    v_last    = (v_cnt_q == VLast);
    raw_de    = run && (h_cnt_q < HAct) && (v_cnt_q < VAct);
    raw_hs    = !(run && (h_cnt_q >= HSyncS) && (h_cnt_q < HSyncE));
    raw_vs    = !(run && (v_cnt_q >= VSyncS) && (v_cnt_q < VSyncE));
    new_frame = run && (h_cnt_q == '0) && (v_cnt_q == VAct);
  end

  // Counters rest at the first blanking line so RUN opens with a full vertical blank,
  // giving the buffer a whole blanking interval to fill before the first active pixel.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StPrime;
      end
      StPrime: begin
        if (!enable) state_d = StIdle;
        else if (rd_usedw >= PrimeLv) state_d = StRun;
      end
      StRun: begin
        if (h_last && v_last && !enable) begin
          state_d = StIdle;
          h_cnt_d = '0;
          v_cnt_d = VAct;
        end else if (h_last) begin
          h_cnt_d = '0;
          v_cnt_d = v_last ? '0 : v_cnt_q + CntOne;
        end else begin
          h_cnt_d = h_cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sync/DE ride a pipeline one stage longer than the read latency so they line up with
  // the registered pixel; the pixel register is gated by the stage matching iData validity.
  always_comb begin
    de_pipe_d = {de_pipe_q[PipeLen-2:0], raw_de};
    hs_pipe_d = {hs_pipe_q[PipeLen-2:0], raw_hs};
    vs_pipe_d = {vs_pipe_q[PipeLen-2:0], raw_vs};
    r_d       = 8'd0;
    g_d       = 8'd0;
    b_d       = 8'd0;
    if (de_pipe_q[GateIdx]) begin
      r_d = iData[23:16];
      g_d = iData[15:8];
      b_d = iData[7:0];
    end
    uf_d = uf_q | (raw_de & rd_empty);
    fc_d = new_frame ? fc_q + 8'd1 : fc_q;
  end

  always_ff @(posedge dvi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      h_cnt_q   <= '0;
      v_cnt_q   <= VAct;
      de_pipe_q <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      uf_q      <= 1'b0;
      fc_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      uf_q      <= uf_d;
      fc_q      <= fc_d;
    end
  end

  assign rd_req       = raw_de;
  assign read_init    = run;
  assign rd_new_frame = new_frame;
  assign oR           = r_q;
  assign oG           = g_q;
  assign oB           = b_q;
  assign oDE          = de_pipe_q[PipeLen-1];
  assign oHS          = hs_pipe_q[PipeLen-1];
  assign oVS          = vs_pipe_q[PipeLen-1];
  assign oUnderflow   = uf_q;
  assign oFrameCnt    = fc_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen on a shrunken raster: cycle model for timing outputs,
// a read-FIFO model feeding iData and a pixel scoreboard checked on every oDE cycle.
module tb_dvi_timing_gen;

  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int unsigned LAT = 2, PL = 256;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic        dvi_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] iData = 32'd0;
  logic [8:0]  rd_usedw = 9'd0;
  logic        rd_empty = 1'b0;
  logic        rd_req, read_init, rd_new_frame, oHS, oVS, oDE, oUnderflow;
  logic [7:0]  oR, oG, oB, oFrameCnt;

  always #5 dvi_clk = ~dvi_clk;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RD_LATENCY(LAT), .PRIME_LEVEL(PL)
  ) dut (
    .dvi_clk(dvi_clk), .reset_n(reset_n), .enable(enable), .iData(iData),
    .rd_usedw(rd_usedw), .rd_empty(rd_empty), .rd_req(rd_req), .read_init(read_init),
    .rd_new_frame(rd_new_frame), .oR(oR), .oG(oG), .oB(oB), .oHS(oHS), .oVS(oVS),
    .oDE(oDE), .oUnderflow(oUnderflow), .oFrameCnt(oFrameCnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  typedef enum int {MIdle, MPrime, MRun} mst_e;
  mst_e        m_st;
  int unsigned m_h, m_v;
  logic        m_uf;
  logic [7:0]  m_fc;
  logic [2:0]  m_hist [LAT+1];  // {de, hs, vs} of earlier cycles, [0] most recent

  logic        dl_v [LAT];
  logic [31:0] dl_w [LAT];
  logic [23:0] exp_q [$];
  logic [23:0] pix_ctr = 24'h000000;

  int unsigned tot_req = 0, req_in_frame, run_start, last_nf, line_req_cyc = 0;
  int unsigned de_run, de_lines, hs_low;
  logic        seen_nf, first_req_pending, prev_req, prev_de, prev_hs, prev_ri;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic f_act();
    return (m_st == MRun) && (m_h < HA) && (m_v < VA);
  endfunction
  function automatic logic f_hs();
    return !((m_st == MRun) && (m_h >= HA + HF) && (m_h < HA + HF + HS));
  endfunction
  function automatic logic f_vs();
    return !((m_st == MRun) && (m_v >= VA + VF) && (m_v < VA + VF + VS));
  endfunction
  function automatic logic f_nf();
    return (m_st == MRun) && (m_h == 0) && (m_v == VA);
  endfunction

  task automatic model_clear();
    m_st = MIdle; m_h = 0; m_v = VA; m_uf = 1'b0; m_fc = 8'd0;
    for (int i = 0; i <= LAT; i++) m_hist[i] = 3'b011;
    for (int i = 0; i < LAT; i++) begin dl_v[i] = 1'b0; dl_w[i] = 32'd0; end
    exp_q.delete();
    seen_nf = 1'b0; first_req_pending = 1'b0; req_in_frame = 0;
    de_run = 0; de_lines = 0; hs_low = 0;
    prev_req = 1'b0; prev_de = 1'b0; prev_hs = 1'b1; prev_ri = 1'b0;
  endtask

  // Uses the inputs as driven for the current cycle to move the model to the next one.
  task automatic advance();
    logic [31:0] r, w;
    if (!reset_n) begin
      model_clear();
      return;
    end
    for (int i = LAT - 1; i > 0; i--) begin dl_v[i] = dl_v[i-1]; dl_w[i] = dl_w[i-1]; end
    dl_v[0] = rd_req;
    dl_w[0] = 32'd0;
    if (rd_req) begin
      r = $urandom();
      w = rd_empty ? 32'd0 : {r[7:0], pix_ctr};
      pix_ctr = pix_ctr + 24'h010307;
      dl_w[0] = w;
      exp_q.push_back(w[23:0]);
    end
    for (int i = LAT; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = {f_act(), f_hs(), f_vs()};
    if (f_act() && rd_empty) m_uf = 1'b1;
    if (f_nf()) m_fc = m_fc + 8'd1;
    case (m_st)
      MIdle:  if (enable) m_st = MPrime;
      MPrime: if (!enable) m_st = MIdle; else if (32'(rd_usedw) >= PL) m_st = MRun;
      default: begin
        if (m_h == HT - 1 && m_v == VT - 1 && !enable) begin
          m_st = MIdle; m_h = 0; m_v = VA;
        end else if (m_h == HT - 1) begin
          m_h = 0; m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
    endcase
  endtask

  task automatic check();
    logic [23:0] e;
    iData = dl_v[LAT-1] ? dl_w[LAT-1] : $urandom();
    chk("rd_req", 32'(rd_req), 32'(f_act()));
    chk("read_init", 32'(read_init), 32'(m_st == MRun));
    chk("rd_new_frame", 32'(rd_new_frame), 32'(f_nf()));
    chk("oDE", 32'(oDE), 32'(m_hist[LAT][2]));
    chk("oHS", 32'(oHS), 32'(m_hist[LAT][1]));
    chk("oVS", 32'(oVS), 32'(m_hist[LAT][0]));
    chk("oUnderflow", 32'(oUnderflow), 32'(m_uf));
    chk("oFrameCnt", 32'(oFrameCnt), 32'(m_fc));
    if (oDE === 1'b1) begin
      chk("pix_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pixel", 32'({oR, oG, oB}), 32'(e));
      end
    end else begin
      chk("pix_blank", 32'({oR, oG, oB}), 32'd0);
    end
    if (rd_req) begin tot_req++; req_in_frame++; end
    if (read_init && !prev_ri) begin run_start = cyc; first_req_pending = 1'b1; end
    if (!read_init) seen_nf = 1'b0;
    if (rd_req && !prev_req) begin
      line_req_cyc = cyc;
      if (first_req_pending) begin
        chk("first_req_delay", cyc - run_start, (VT - VA) * HT);
        first_req_pending = 1'b0;
      end
    end
    if (rd_new_frame) begin
      if (seen_nf) begin
        chk("reqs_per_frame", req_in_frame, HA * VA);
        chk("frame_period", cyc - last_nf, HT * VT);
        chk("lines_per_frame", de_lines, VA);
      end
      seen_nf = 1'b1; last_nf = cyc; req_in_frame = 0; de_lines = 0;
    end
    if (oDE) de_run++;
    else if (prev_de) begin chk("de_per_line", de_run, HA); de_run = 0; de_lines++; end
    if (!oHS) begin
      if (prev_hs && (cyc - line_req_cyc < HT))
        chk("hs_offset", cyc - line_req_cyc, HA + HF + LAT + 1);
      hs_low++;
    end else if (!prev_hs) begin
      chk("hs_width", hs_low, HS);
      hs_low = 0;
    end
    prev_req = rd_req; prev_de = oDE; prev_hs = oHS; prev_ri = read_init;
  endtask

  task automatic step();
    advance();
    @(posedge dvi_clk);
    #1;
    cyc++;
    check();
  endtask

  // which: 0 = rd_req high, 1 = rd_new_frame high, 2 = read_init low, 3 = read_init high
  function automatic logic cond(input int which);
    case (which)
      0: return rd_req === 1'b1;
      1: return rd_new_frame === 1'b1;
      2: return read_init === 1'b0;
      default: return read_init === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which);
    for (int i = 0; i < 2 * HT * VT && !cond(which); i++) step();
    chk(tag, 32'(cond(which)), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_read_init"}, 32'(read_init), 32'd0);
    chk({tag, "_new_frame"}, 32'(rd_new_frame), 32'd0);
    chk({tag, "_rgb"}, 32'({oR, oG, oB}), 32'd0);
    chk({tag, "_syncs_de"}, 32'({oHS, oVS, oDE}), 32'b110);
    chk({tag, "_uf"}, 32'(oUnderflow), 32'd0);
    chk({tag, "_fcnt"}, 32'(oFrameCnt), 32'd0);
  endtask

  int unsigned snap;

  initial begin
    model_clear();
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("por");
    repeat (3) step();
    reset_n = 1'b1;

    // Priming: level one short of the threshold must hold the generator in blanking.
    enable = 1'b1;
    rd_usedw = 9'd255;
    repeat (1000) step();
    chk("prime_no_req", tot_req, 0);
    chk("prime_hold", 32'(read_init), 32'd0);
    rd_usedw = 9'd256;
    step();
    chk("run_entry", 32'(read_init), 32'd1);

    // Full frames, then a single empty-FIFO read.
    repeat (HT * VT) step();
    wait_for("wait_req_uf", 0);
    chk("uf_pre", 32'(oUnderflow), 32'd0);
    rd_empty = 1'b1;
    step();
    rd_empty = 1'b0;
    chk("uf_rise", 32'(oUnderflow), 32'd1);

    // Drop enable a couple of lines into the next frame; it must finish that frame.
    wait_for("wait_nf", 1);
    repeat ((VT - VA + 2) * HT) step();
    enable = 1'b0;
    wait_for("wait_idle", 2);
    snap = tot_req;
    repeat (200) step();
    chk("idle_no_req", tot_req - snap, 0);
    chk("uf_sticky", 32'(oUnderflow), 32'd1);

    // Restart, then an asynchronous reset in the middle of an active line.
    enable = 1'b1;
    wait_for("wait_rerun", 3);
    wait_for("wait_req_rst", 0);
    repeat (7) step();
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_reprime", 32'(read_init), 32'd0);
    wait_for("wait_run_after_rst", 3);
    repeat (2 * HT * VT) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dvi_timing_gen.md
# dvi_timing_gen

Display-side raster timing generator and pixel unpacker on `dvi_clk`, directly downstream of the DDR2 frame buffer. Produces 640x480@60 VGA-style sync/DE timing and issues read strobes to the buffer's read FIFO ahead of the active region to cover its read latency. Unpacks 32-bit buffer words into 8-bit RGB for the DVI transmitter, and signals frame boundaries back to the buffer. Stays in blanking until the read FIFO has primed, and flags underflow.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch
- `RD_LATENCY`, 2, cycles from `rd_req` to valid `iData`
- `PRIME_LEVEL`, 256, minimum `rd_usedw` before the first frame starts

- `dvi_clk` in 1: pixel clock; all logic on its rising edge
- `reset_n` in 1: asynchronous active-low reset
- `enable` in 1: run request
- `iData` in 32: pixel word from buffer; `[23:16]`=R, `[15:8]`=G, `[7:0]`=B, `[31:24]` ignored
- `rd_usedw` in 9: read-FIFO fill level (read side)
- `rd_empty` in 1: read-FIFO empty (read side)
- `rd_req` out 1: pixel read strobe, drives the buffer's `read_rstn`
- `read_init` out 1: buffer read enable, high in RUN
- `rd_new_frame` out 1: one-cycle frame-boundary pulse to the buffer
- `oR`, `oG`, `oB` out 8 each: pixel data
- `oHS`, `oVS` out 1: syncs, active-low
- `oDE` out 1: data enable
- `oUnderflow` out 1: sticky underflow flag
- `oFrameCnt` out 8: completed-frame counter

## Operation
- Counters: `h_cnt` 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800). `v_cnt` 0..V_TOTAL-1 (525) increments when `h_cnt` wraps. Active region: `h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`. Counters are wide enough for the totals (10 bits at defaults).
- Raw sync: hsync is low for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vsync uses the same rule on `v_cnt`.
- FSM states:
  - IDLE: counters held at `h_cnt=0`, `v_cnt=V_ACTIVE`; `read_init=0`, `rd_req=0`, syncs high. Go to PRIME when `enable=1`.
  - PRIME: counters held. Go to RUN when `rd_usedw>=PRIME_LEVEL`. Return to IDLE if `enable=0`.
  - RUN: counters free-run, starting in vertical front porch. `read_init=1`. `rd_req` equals raw active.
- RUN to IDLE: only at end of frame (`h_cnt=H_TOTAL-1`, `v_cnt=V_TOTAL-1`) with `enable=0`. A mid-frame `enable` drop is ignored until that point.
- `rd_new_frame` is pulsed in RUN when `h_cnt=0 && v_cnt=V_ACTIVE`, i.e. first blanking line after the last active pixel. This resets the buffer's DRAM read sequencer for the next frame.
- `oFrameCnt` increments (mod 256) on each `rd_new_frame` pulse.
- Underflow: `oUnderflow` is set when `rd_req && rd_empty`, and is cleared only by reset. When underflow occurs, pixel output still follows `iData` (the buffer supplies zero).

## Timing
- Reset values: all outputs 0, except `oHS`, `oVS` = 1. FSM in IDLE, `oFrameCnt`=0.
- `rd_req` is combinational from registered state and counters, issued at cycle t. `iData` is valid at t+RD_LATENCY and registered into `oR/oG/oB` at t+RD_LATENCY+1.
- `oDE`, `oHS`, `oVS` are raw active/sync delayed RD_LATENCY+1 registers. Pixel and sync alignment is therefore exact.
- When `oDE=0`, `oR/oG/oB` = 0.
- Entering RUN: the first `rd_req` comes V_FP+V_SYNC+V_BP lines (45×800 = 36000 cycles) after the transition.
- `rd_req` count per frame is exactly H_ACTIVE×V_ACTIVE (307200), and `rd_new_frame` occurs once per frame.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. After reset, restart requires PRIME again.

## Test plan
- Reset then `enable=1`, `rd_usedw` held at 255 for 1000 cycles, then 256: no `rd_req` while below 256; RUN entered the cycle after the level reaches 256; first `rd_req` 36000 cycles later.
- RUN with `iData` = incrementing counter aligned to `rd_req`: each `oDE` cycle shows R,G,B equal to bytes of the value presented 1 cycle earlier; 640 `oDE` cycles per line, 480 lines; `oHS` low for 96 cycles starting 656+3 cycles after the line's first `rd_req`.
- Count per frame: `rd_req` = 307200, `rd_new_frame` = 1 (at `v_cnt=480`, `h_cnt=0`), `oFrameCnt` steps by 1; frame period 420000 cycles.
- `enable` dropped at line 100 of frame: frame completes normally, IDLE entered at frame end, `read_init` falls, no further `rd_req`.
- `rd_empty=1` during one `rd_req`: `oUnderflow` rises the next cycle and stays high until `reset_n` pulses low.
- `reset_n` asserted asynchronously mid-line: outputs at reset values immediately; after release with `rd_usedw` ≥256, sequence restarts from PRIME.
